// File: rtl/mac_accumulator.sv
// Purpose: accumulates 32-bit unsigned products into an ACC_W-bit frame sum of up to N_TERMS terms.
// Latency: out_valid rises one cycle after the closing term is accepted; one frame per (terms+1) cycles at best.
// Backpressure: the result is held in DONE until out_ready; in_ready stays low until the cycle after it is taken.
module mac_accumulator #(
   parameter int  ACC_W   = 40,
   parameter int  N_TERMS = 16,
   localparam int CNT_W   = $clog2(N_TERMS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_prod,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_acc,
   output logic [CNT_W-1:0] out_terms,
   output logic             out_ovf
);

   typedef enum logic {ACCUM, DONE} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic             ovf;
   logic             accept;
   logic             close;
   logic             take;
   logic [ACC_W:0]   sum;

   // Ready and valid decode purely from state; reset masks ready so nothing is taken mid-reset.
   assign in_ready  = (state == ACCUM) && !rst;
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready;
   assign take      = (state == DONE) && out_ready;

   // One extra bit catches the carry out of the accumulator's top bit.
   assign sum   = {1'b0, acc} + {{(ACC_W + 1 - 32){1'b0}}, in_prod};
   // Early close and the natural last term collapse into one close event.
   assign close = in_last || (cnt == CNT_W'(N_TERMS - 1));

   assign out_acc   = acc;
   assign out_terms = cnt;
   assign out_ovf   = ovf;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ACCUM;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: close a frame on its final accept, reopen once the result is taken.
   always_comb begin
      state_nxt = state;
      case (state)
         ACCUM: if (accept && close) state_nxt = DONE;
         DONE:  if (out_ready)       state_nxt = ACCUM;
         default: state_nxt = ACCUM;
      endcase
   end

   // Datapath: sum, term count and sticky carry; cleared on reset and when the result is taken.
   always_ff @(posedge clk) begin
      if (rst || take) begin
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else if (accept) begin
         acc <= sum[ACC_W-1:0];
         ovf <= ovf | sum[ACC_W];
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_mac_accumulator.sv
// Purpose: self-checking bench driving two accumulator widths (40 and 32 bits) from one stimulus stream.
// Latency: the frame model predicts register contents one edge ahead and is compared on every falling edge.
// Backpressure: out_ready is exercised both held low in DONE and randomly toggled.
module tb_mac_accumulator;

   localparam int NT = 4;
   localparam int CW = $clog2(NT + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic [31:0]   in_prod = '0;
   logic          in_last = 1'b0;
   logic          out_ready = 1'b1;

   logic          a_in_ready, a_out_valid, a_out_ovf;
   logic [39:0]   a_out_acc;
   logic [CW-1:0] a_out_terms;
   logic          b_in_ready, b_out_valid, b_out_ovf;
   logic [31:0]   b_out_acc;
   logic [CW-1:0] b_out_terms;

   int tests = 0;
   int fails = 0;

   // Frame model: the pending flag and the exact (unwrapped) total of the current frame.
   logic          m_pend = 1'b0;
   int            m_cnt = 0;
   logic [127:0]  m_total = '0;

   // Observations of the 40-bit instance's results, used by the literal checks.
   int            vcount = 0;
   int            rcount = 0;
   logic [39:0]   r_acc40;
   logic [31:0]   r_acc32;
   logic [CW-1:0] r_terms;
   logic          r_ovf40, r_ovf32;
   logic          prev_valid = 1'b0;

   mac_accumulator #(.ACC_W(40), .N_TERMS(NT)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_prod(in_prod), .in_last(in_last), .out_valid(a_out_valid),
      .out_ready(out_ready), .out_acc(a_out_acc), .out_terms(a_out_terms),
      .out_ovf(a_out_ovf)
   );

   mac_accumulator #(.ACC_W(32), .N_TERMS(NT)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_prod(in_prod), .in_last(in_last), .out_valid(b_out_valid),
      .out_ready(out_ready), .out_acc(b_out_acc), .out_terms(b_out_terms),
      .out_ovf(b_out_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare DUTs against the model, record results, then advance the model across the next edge.
   always @(negedge clk) begin
      logic [127:0] mask40, mask32;
      mask40 = (128'd1 << 40) - 128'd1;
      mask32 = (128'd1 << 32) - 128'd1;

      chk("a_in_ready", {127'd0, a_in_ready}, {127'd0, !m_pend && !rst});
      chk("b_in_ready", {127'd0, b_in_ready}, {127'd0, !m_pend && !rst});
      chk("a_out_valid", {127'd0, a_out_valid}, {127'd0, m_pend});
      chk("b_out_valid", {127'd0, b_out_valid}, {127'd0, m_pend});
      if (m_pend) begin
         chk("a_out_acc", {88'd0, a_out_acc}, m_total & mask40);
         chk("b_out_acc", {96'd0, b_out_acc}, m_total & mask32);
         chk("a_out_terms", {{(128-CW){1'b0}}, a_out_terms}, 128'(m_cnt));
         chk("b_out_terms", {{(128-CW){1'b0}}, b_out_terms}, 128'(m_cnt));
         chk("a_out_ovf", {127'd0, a_out_ovf}, {127'd0, (m_total >> 40) != 0});
         chk("b_out_ovf", {127'd0, b_out_ovf}, {127'd0, (m_total >> 32) != 0});
      end

      if (a_out_valid) begin
         vcount++;
         if (!prev_valid) rcount++;
         r_acc40 = a_out_acc;
         r_acc32 = b_out_acc;
         r_terms = a_out_terms;
         r_ovf40 = a_out_ovf;
         r_ovf32 = b_out_ovf;
      end
      prev_valid = a_out_valid && !out_ready;

      if (rst) begin
         m_pend  = 1'b0;
         m_cnt   = 0;
         m_total = '0;
      end else if (m_pend) begin
         if (out_ready) begin
            m_pend  = 1'b0;
            m_cnt   = 0;
            m_total = '0;
         end
      end else if (in_valid) begin
         m_total = m_total + {96'd0, in_prod};
         m_cnt   = m_cnt + 1;
         if (in_last || m_cnt == NT) m_pend = 1'b1;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] p, input logic l);
      in_valid = 1'b1;
      in_prod  = p;
      in_last  = l;
      idle(1);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   initial begin
      int rc0, vc0;

      // Reset state.
      rst = 1'b1;
      idle(2);
      @(negedge clk);
      chk("rst_out_valid", {127'd0, a_out_valid}, 128'd0);
      chk("rst_in_ready", {127'd0, a_in_ready}, 128'd0);
      chk("rst_out_acc", {88'd0, a_out_acc}, 128'd0);
      chk("rst_out_terms", {{(128-CW){1'b0}}, a_out_terms}, 128'd0);
      chk("rst_out_ovf", {127'd0, a_out_ovf}, 128'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      idle(1);

      // Four back-to-back terms close the frame on the term limit.
      rc0 = rcount; vc0 = vcount;
      send(10, 0); send(20, 0); send(30, 0); send(40, 0);
      idle(3);
      chk("t1_frames", 128'(rcount - rc0), 128'd1);
      chk("t1_valid_cycles", 128'(vcount - vc0), 128'd1);
      chk("t1_acc", {88'd0, r_acc40}, 128'd100);
      chk("t1_terms", {{(128-CW){1'b0}}, r_terms}, 128'd4);
      chk("t1_ovf", {127'd0, r_ovf40}, 128'd0);

      // Same terms with idle gaps; in_last on the fourth coincides with the term limit.
      rc0 = rcount;
      for (int i = 1; i <= 4; i++) begin
         send(32'(10 * i), i == 4);
         if (i < 4) idle($urandom_range(1, 3));
      end
      idle(3);
      chk("t2_frames", 128'(rcount - rc0), 128'd1);
      chk("t2_acc", {88'd0, r_acc40}, 128'd100);
      chk("t2_terms", {{(128-CW){1'b0}}, r_terms}, 128'd4);

      // Two all-ones products: wide accumulator holds the sum, narrow one wraps.
      send(32'hFFFF_FFFF, 0); send(32'hFFFF_FFFF, 1);
      idle(3);
      chk("t3_acc40", {88'd0, r_acc40}, 128'h1_FFFF_FFFE);
      chk("t3_ovf40", {127'd0, r_ovf40}, 128'd0);
      chk("t3_acc32", {96'd0, r_acc32}, 128'hFFFF_FFFE);
      chk("t3_ovf32", {127'd0, r_ovf32}, 128'd1);
      chk("t3_terms", {{(128-CW){1'b0}}, r_terms}, 128'd2);

      // Narrow wrap sets the sticky flag; the next frame starts clean.
      send(32'hFFFF_FFFF, 0); send(2, 1);
      idle(3);
      chk("t4_acc32", {96'd0, r_acc32}, 128'd1);
      chk("t4_ovf32", {127'd0, r_ovf32}, 128'd1);
      chk("t4_acc40", {88'd0, r_acc40}, 128'h1_0000_0001);
      send(5, 1);
      idle(3);
      chk("t4b_acc32", {96'd0, r_acc32}, 128'd5);
      chk("t4b_ovf32", {127'd0, r_ovf32}, 128'd0);

      // Result held under backpressure while input keeps offering a term.
      out_ready = 1'b0;
      send(1, 0); send(2, 1);
      vc0 = vcount;
      in_valid = 1'b1; in_prod = 7; in_last = 1'b1;
      idle(5);
      out_ready = 1'b1;
      idle(1);
      chk("t5_hold_cycles", 128'(vcount - vc0), 128'd6);
      chk("t5_held_acc", {88'd0, r_acc40}, 128'd3);
      idle(1);
      in_valid = 1'b0; in_last = 1'b0;
      idle(3);
      chk("t5_next_acc", {88'd0, r_acc40}, 128'd7);
      chk("t5_next_terms", {{(128-CW){1'b0}}, r_terms}, 128'd1);

      // Reset mid-frame discards the partial sum.
      rc0 = rcount;
      send(1, 0); send(2, 0);
      rst = 1'b1; in_valid = 1'b1; in_prod = 9;
      idle(1);
      rst = 1'b0; in_valid = 1'b0;
      send(3, 0); send(4, 1);
      idle(3);
      chk("t6_frames", 128'(rcount - rc0), 128'd1);
      chk("t6_acc", {88'd0, r_acc40}, 128'd7);
      chk("t6_terms", {{(128-CW){1'b0}}, r_terms}, 128'd2);

      // Random traffic checked cycle by cycle against the frame model.
      for (int c = 0; c < 600; c++) begin
         rst       = ($urandom_range(0, 99) == 0);
         in_valid  = ($urandom_range(0, 2) != 0);
         in_prod   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
         in_last   = ($urandom_range(0, 3) == 0);
         out_ready = ($urandom_range(0, 2) != 0);
         idle(1);
      end
      rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
      idle(4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
